// File: rtl/hci_delayed_copy_sink_if.sv
// hci_core_intf: HCI core request/response bundle.
// Request side : req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready
// Response side: gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
// Modports: master/initiator drive requests, slave/target drive responses,
// monitor only observes every signal.
interface hci_core_intf #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned BW = DW / 8,
  parameter int unsigned UW = 2,
  parameter int unsigned IW = 2,
  parameter int unsigned EW = 4
) ();
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [BW-1:0] be;
  logic          r_ready;
  logic [UW-1:0] user;
  logic [IW-1:0] id;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic          r_opc;
  logic [EW-1:0] ecc;
  logic          egnt;
  logic          r_evalid;
  logic          ereq;
  logic          r_eready;
  logic [EW-1:0] r_ecc;

  modport master (
    output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
  );
  modport slave (
    input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    output gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
  );
  modport initiator (
    output req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
  );
  modport target (
    input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    output gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
  );
  modport monitor (
    input  req, add, wen, data, be, r_ready, user, id, ecc, ereq, r_eready,
    input  gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc
  );
endinterface

// File: rtl/hci_delayed_copy_sink.sv
// hci_delayed_copy_sink: compares N_CH main HCI streams with copy streams that
// lag them by DELAY cycles. Main request signatures and responses run through
// a per-channel delay line; the tail response is replayed on the copy side and
// the tail signature is compared against the live copy request.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   tcdm_main[N_CH]     observed main streams (monitor only)
//   tcdm_copy[N_CH]     copy streams; responses driven here
//   enable_i[N_CH]      per-channel compare enable (does not gate responses)
//   clear_i             synchronous clear of sticky flag, counter, capture
//   fault_o / fault_any_o / fault_sticky_o / fault_cnt_o / first_fault_ch_o
// The AW..EW parameters must match the widths of the connected interfaces.
module hci_delayed_copy_sink #(
  parameter int unsigned N_CH  = 1,
  parameter int unsigned DELAY = 2,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned BW    = DW / 8,
  parameter int unsigned UW    = 2,
  parameter int unsigned IW    = 2,
  parameter int unsigned EW    = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  hci_core_intf.monitor                                  tcdm_main [N_CH],
  hci_core_intf.target                                   tcdm_copy [N_CH],
  input  logic [N_CH-1:0]                                enable_i,
  input  logic                                           clear_i,
  output logic [N_CH-1:0]                                fault_o,
  output logic                                           fault_any_o,
  output logic                                           fault_sticky_o,
  output logic [CNT_W-1:0]                               fault_cnt_o,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]     first_fault_ch_o
);

  localparam int unsigned SIG_W = 1 + AW + 1 + DW + BW + UW + IW + EW + 3;
  localparam int unsigned RSP_W = 1 + DW + 1 + UW + IW + 1 + 1 + 1 + EW;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Lowest set bit index of a channel vector (0 when empty).
  function automatic logic [CH_W-1:0] lowest_idx(input logic [N_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  logic [SIG_W-1:0] main_sig [N_CH];
  logic [SIG_W-1:0] copy_sig [N_CH];
  logic [SIG_W-1:0] tail_sig [N_CH];
  logic [RSP_W-1:0] main_rsp [N_CH];
  logic [RSP_W-1:0] copy_rsp [N_CH];
  logic             tail_valid;
  logic [N_CH-1:0]  mismatch;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign main_sig[c] = {tcdm_main[c].req, tcdm_main[c].add, tcdm_main[c].wen,
                          tcdm_main[c].data, tcdm_main[c].be, tcdm_main[c].user,
                          tcdm_main[c].id, tcdm_main[c].ecc, tcdm_main[c].ereq,
                          tcdm_main[c].r_ready, tcdm_main[c].r_eready};
    assign copy_sig[c] = {tcdm_copy[c].req, tcdm_copy[c].add, tcdm_copy[c].wen,
                          tcdm_copy[c].data, tcdm_copy[c].be, tcdm_copy[c].user,
                          tcdm_copy[c].id, tcdm_copy[c].ecc, tcdm_copy[c].ereq,
                          tcdm_copy[c].r_ready, tcdm_copy[c].r_eready};
    assign main_rsp[c] = {tcdm_main[c].gnt, tcdm_main[c].r_data, tcdm_main[c].r_valid,
                          tcdm_main[c].r_user, tcdm_main[c].r_id, tcdm_main[c].r_opc,
                          tcdm_main[c].egnt, tcdm_main[c].r_evalid, tcdm_main[c].r_ecc};
    assign {tcdm_copy[c].gnt, tcdm_copy[c].r_data, tcdm_copy[c].r_valid,
            tcdm_copy[c].r_user, tcdm_copy[c].r_id, tcdm_copy[c].r_opc,
            tcdm_copy[c].egnt, tcdm_copy[c].r_evalid, tcdm_copy[c].r_ecc} = copy_rsp[c];
  end

  if (DELAY == 0) begin : g_lock
    assign tail_valid = 1'b1;

    // Lock-step: compare against live main, forward responses combinationally.
    always_comb begin
      for (int c = 0; c < N_CH; c++) begin
        tail_sig[c] = main_sig[c];
        copy_rsp[c] = main_rsp[c];
      end
    end
  end else begin : g_dly
    logic [DELAY-1:0] valid_q, valid_d;
    logic [SIG_W-1:0] sig_q [N_CH][DELAY];
    logic [SIG_W-1:0] sig_d [N_CH][DELAY];
    logic [RSP_W-1:0] rsp_q [N_CH][DELAY];
    logic [RSP_W-1:0] rsp_d [N_CH][DELAY];

    // Shift every stage one step towards the tail; a 1 enters the valid chain.
    always_comb begin
      valid_d = DELAY'({valid_q, 1'b1});
      for (int c = 0; c < N_CH; c++) begin
        sig_d[c][0] = main_sig[c];
        rsp_d[c][0] = main_rsp[c];
        for (int s = 1; s < DELAY; s++) begin
          sig_d[c][s] = sig_q[c][s-1];
          rsp_d[c][s] = rsp_q[c][s-1];
        end
      end
    end

    // Valid chain: reset flushes it so the fill window is never checked.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q <= '0;
      end else begin
        valid_q <= valid_d;
      end
    end

    // Payload stages carry no reset; they are qualified by the valid chain.
    always_ff @(posedge clk_i) begin
      sig_q <= sig_d;
      rsp_q <= rsp_d;
    end

    assign tail_valid = valid_q[DELAY-1];

    // Tail extraction; copy responses read as zero until the line has filled.
    always_comb begin
      for (int c = 0; c < N_CH; c++) begin
        tail_sig[c] = sig_q[c][DELAY-1];
        if (tail_valid) begin
          copy_rsp[c] = rsp_q[c][DELAY-1];
        end else begin
          copy_rsp[c] = '0;
        end
      end
    end
  end

  // Per-channel compare of delayed main signature against live copy.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      mismatch[c] = enable_i[c] & tail_valid & (tail_sig[c] != copy_sig[c]);
    end
  end

  logic [N_CH-1:0]  fault_q, fault_d;
  logic             any_q, any_d;
  logic             sticky_q, sticky_d, sticky_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [CH_W-1:0]  first_q, first_d, first_base;

  // Status update: clear is applied first so a same-cycle mismatch wins.
  always_comb begin
    fault_d     = mismatch;
    any_d       = |mismatch;
    sticky_base = sticky_q & ~clear_i;
    cnt_base    = clear_i ? '0 : cnt_q;
    first_base  = clear_i ? '0 : first_q;
    sticky_d    = sticky_base;
    cnt_d       = cnt_base;
    first_d     = first_base;
    if (any_d) begin
      sticky_d = 1'b1;
      if (!sticky_base) begin
        first_d = lowest_idx(mismatch);
      end else begin
        first_d = first_base;
      end
      if (cnt_base != CNT_MAX) begin
        cnt_d = cnt_base + CNT_W'(1);
      end else begin
        cnt_d = cnt_base;
      end
    end else begin
      sticky_d = sticky_base;
    end
  end

  // Status registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_q  <= '0;
      any_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      first_q  <= '0;
    end else begin
      fault_q  <= fault_d;
      any_q    <= any_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  assign fault_o          = fault_q;
  assign fault_any_o      = any_q;
  assign fault_sticky_o   = sticky_q;
  assign fault_cnt_o      = cnt_q;
  assign first_fault_ch_o = first_q;

endmodule

// File: doc/hci_delayed_copy_sink.md
# hci_delayed_copy_sink

Time-shifted, multi-channel successor of the HCI copy checker. It compares `N_CH` main HCI streams against redundant copy streams that lag their main counterparts by a fixed `DELAY` cycles. Main-side request signatures and main-side responses are buffered in per-channel delay lines. The copy logic therefore sees identical responses `DELAY` cycles late, and faults that hit both copies at once (common-mode) cannot pass unnoticed. It sits at the tail of a duplicated HCI module chain, next to the source-side block that builds the delayed copy.

## Interface
Parameters:
- `N_CH`, 1: number of main/copy channel pairs (≥1).
- `DELAY`, 2: copy lag in cycles (0..15). 0 means lock-step compare with no buffering.
- `CNT_W`, 16: width of the fault event counter.
- Request field widths (add, data, be, user, id, ecc) come from the connected interface parameters.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `tcdm_main[N_CH]` hci_core_intf.monitor: observed main streams.
- `tcdm_copy[N_CH]` hci_core_intf.target: copy streams. The response side is driven by this block.
- `enable_i` in N_CH: per-channel check enable. 0 masks compare results only; it does not mask response forwarding.
- `clear_i` in 1: synchronous clear of sticky flag, counter and first-channel capture.
- `fault_o` out N_CH: per-channel registered mismatch.
- `fault_any_o` out 1: OR of `fault_o`.
- `fault_sticky_o` out 1: set on first fault, held until `clear_i`.
- `fault_cnt_o` out CNT_W: saturating count of cycles with at least one channel fault.
- `first_fault_ch_o` out max(1,$clog2(N_CH)): lowest faulting channel index of the cycle that set the sticky flag.

## Operation
- **Request signature per channel**, the concatenation of: req, add, wen, data, be, user, id, ecc, ereq, r_ready, r_eready.
- **Response bundle per channel**, the concatenation of: gnt, r_data, r_valid, r_user, r_id, r_opc, egnt, r_evalid, r_ecc.
- **Delay line per channel:** DELAY-stage shift register holding {valid, signature, response}. It shifts every cycle with no stall.
  - The valid bit enters as 1 and is cleared by reset.
  - Data stages are not reset.
- **Copy response:** each tcdm_copy response output equals the delay-line tail response.
  - While the tail valid bit is 0, all copy responses drive 0 (gnt=0, r_valid=0).
  - DELAY=0: copy responses are combinationally equal to main responses.
- **Compare per channel:** mismatch = enable_i[c] & tail_valid & (tail_signature != current copy signature).
  - DELAY=0 compares current main against current copy, with tail_valid treated as 1.
- **Registered outputs:** `fault_o[c]` is the registered mismatch; `fault_any_o` is the OR of the registered bits.
- **Sticky flag and capture:** `fault_sticky_o` sets when any mismatch occurs while it is 0. `first_fault_ch_o` captures the lowest set index in the same edge. Later faults do not update the capture.
- **Counter:** `fault_cnt_o` increments by 1 per cycle with any mismatch, regardless of how many channels fault. It saturates at 2^CNT_W−1 with no wrap.
- **clear_i:** clears sticky, counter and capture.
  - If a mismatch occurs in the same cycle, the mismatch wins: sticky=1, counter=1, capture = the new index.
- **Reset value of every output:** 0. Reset mid-operation flushes all valid bits, so the first DELAY cycles after reset release are unchecked and copy responses are 0.

## Timing
- Main signature at cycle t is compared with copy signature at cycle t+DELAY. `fault_o` is high in cycle t+DELAY+1 and lasts one cycle per mismatching cycle.
- Copy response at t+DELAY equals main response at t, exactly.
- Sticky, counter and capture update on the same edge as `fault_o`.
- No combinational path from copy request inputs to any output. The only combinational paths are copy responses when DELAY=0.
- Checker latency does not backpressure main; the main stream is only monitored.

## Test plan
- **Clean run:** N_CH=2, DELAY=2; random traffic, copy = main delayed 2 cycles → fault outputs stay 0, fault_cnt_o=0, and copy gnt/r_data match main 2 cycles earlier.
- **Single corruption:** flip copy add bit 3 on ch1 at cycle 20 → fault_o=2'b10 in cycle 21 only, sticky=1, cnt=1, first_fault_ch_o=1.
- **Fill window:** release reset, with copy driving garbage for the first 2 cycles → no fault, and copy gnt=0 during those cycles.
- **Mask and multi-fault:** enable_i=2'b01 with faults on both channels for 3 cycles → only fault_o[0] asserts, cnt=3, capture=0.
- **Clear collision:** clear_i in the same cycle as a new ch0 mismatch, with prior cnt=5 → cnt=1, sticky=1. Clear alone → cnt=0, sticky=0.
- **Saturation and lock-step:** CNT_W=2 with 6 fault cycles → cnt holds 3. Then DELAY=0 with a data mismatch at cycle t → fault_o at t+1.
